// File: rtl/dram_fifo_sync.sv
// Single-clock FWFT FIFO over 128x1-style dual-port distributed RAM slices.
// One RAM slice per data bit; head entry is held in a registered output stage.
module dram_fifo_sync_slice #(
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [AW-1:0] ra_i,
  input  logic          d_i,
  output logic          dpo_o
);
  localparam int N = 1 << AW;

  logic [N-1:0] mem_q;

  // Storage is never reset, like the primitive it models
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wa_i] <= d_i;
    end
  end

  assign dpo_o = mem_q[ra_i];
endmodule

module dram_fifo_sync #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 7,
  parameter int AFULL_LVL  = 120,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  WR_EN,
  input  logic [DATA_W-1:0]     WR_DATA,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  input  logic                  RD_EN,
  output logic [DATA_W-1:0]     RD_DATA,
  output logic                  VALID,
  output logic                  ALMOST_EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);
  localparam int AW = DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              full_q, afull_q, aempty_q;
  logic              ovf_q, unf_q;

  logic              push, pop, load;
  logic [LW-1:0]     ram_cnt;
  logic [DATA_W-1:0] ram_dout;

  assign push = WR_EN & ~full_q;
  assign pop  = RD_EN & valid_q;

  // Entries still in RAM; same-cycle writes are deliberately not bypassed
  assign ram_cnt = level_q - {{(LW-1){1'b0}}, valid_q};
  assign load    = (~valid_q | pop) & (ram_cnt != '0);

  for (genvar b = 0; b < DATA_W; b++) begin : g_slice
    dram_fifo_sync_slice #(
      .AW(AW)
    ) u_slice (
      .clk_i (CLK),
      .we_i  (push),
      .wa_i  (wr_ptr_q),
      .ra_i  (rd_ptr_q),
      .d_i   (WR_DATA[b]),
      .dpo_o (ram_dout[b])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = ram_dout;
      valid_d  = 1'b1;
    end else if (pop) begin
      valid_d  = 1'b0;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      full_q   <= (level_d == DEPTH_L);
      afull_q  <= (level_d >= AFULL_L);
      aempty_q <= (level_d <= AEMPTY_L);
      ovf_q    <= ovf_q | (WR_EN & full_q);
      unf_q    <= unf_q | (RD_EN & ~valid_q);
    end
  end

  assign FULL         = full_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
  assign LEVEL        = level_q;
  assign VALID        = valid_q;
  assign RD_DATA      = data_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;
endmodule

// File: doc/dram_fifo_sync.md
Name: dram_fifo_sync

Overview:
- Single-clock FIFO built on the 128x1 dual-port distributed-RAM storage model, with DATA_W bit slices in parallel.
- Writer side drives the shared read/write address port. Reader side is the read-back end: it drives the dual-port read address and presents data first-word-fall-through (FWFT) from a registered output stage.
- Used as the standard small elastic buffer between Verilator-simulated Xilinx-style datapaths.

Parameters:
- DATA_W, 8, data width in bits (one 1-bit RAM slice per bit).
- DEPTH_LOG2, 7, log2 of total capacity; capacity DEPTH = 2**DEPTH_LOG2 = 128 entries (output register included).
- AFULL_LVL, 120, ALMOST_FULL asserted when LEVEL >= AFULL_LVL.
- AEMPTY_LVL, 4, ALMOST_EMPTY asserted when LEVEL <= AEMPTY_LVL.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RSTN  in  1  synchronous reset, active-low.
- WR_EN  in  1  push request.
- WR_DATA  in  DATA_W  push data.
- FULL  out  1  LEVEL == DEPTH.
- ALMOST_FULL  out  1  LEVEL >= AFULL_LVL.
- RD_EN  in  1  pop request; consumes RD_DATA when VALID=1.
- RD_DATA  out  DATA_W  registered head-of-FIFO data (FWFT).
- VALID  out  1  RD_DATA holds a valid entry.
- ALMOST_EMPTY  out  1  LEVEL <= AEMPTY_LVL.
- LEVEL  out  DEPTH_LOG2+1  total occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky: write attempted while FULL.
- UNDERFLOW  out  1  sticky: read attempted while VALID=0.

Behaviour:
- Reset: RSTN sampled low on a CLK edge sets write pointer=0, read pointer=0, LEVEL=0, VALID=0, RD_DATA=0, FULL=0, ALMOST_FULL=0, ALMOST_EMPTY=1, OVERFLOW=0, UNDERFLOW=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all entries; the next cycle behaves as fresh reset.
- Push:
  - Accepted iff WR_EN=1 and FULL=0, independent of RD_EN in the same cycle.
  - An accepted push writes RAM at write pointer; the pointer increments modulo DEPTH and wraps silently.
  - WR_EN=1 while FULL=1: data dropped, pointers unchanged, OVERFLOW set.
- Pop:
  - Accepted iff RD_EN=1 and VALID=1.
  - RD_EN=1 while VALID=0: no effect except UNDERFLOW set.
- Output stage (FWFT):
  - When the output register is empty or being popped, and RAM holds at least 1 unread entry, the register loads RAM[read pointer] via the async read port; the read pointer then increments.
  - Write-to-VALID latency: a push into an empty FIFO at edge N gives VALID=1 and RD_DATA=WR_DATA after edge N+1. Same-cycle RAM-write bypass is not permitted.
  - Back-to-back pops with a non-empty RAM keep VALID=1 every cycle (full throughput, one entry per cycle).
  - Pop of the last entry with no RAM data: VALID=0 after that edge; RD_DATA holds its stale value.
- LEVEL:
  - +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither occur.
  - Counts RAM entries plus the output register.
- Full and simultaneous events:
  - FULL with RD_EN=1 and WR_EN=1: pop accepted, push rejected (OVERFLOW set); LEVEL becomes DEPTH-1.
  - LEVEL==1 (entry in output register) with simultaneous push and pop: VALID stays 0 for one cycle, then becomes 1 with the new data (1-cycle bubble permitted).
- Flag timing: FULL, ALMOST_FULL and ALMOST_EMPTY are registered and consistent with LEVEL in the same cycle.
- Sticky flags: OVERFLOW and UNDERFLOW clear only on reset.

Test Plan:
- Reset then 1 push of 0xA5 at edge 1 -> VALID=0 after edge 1, VALID=1 with RD_DATA=0xA5 and LEVEL=1 after edge 2. RD_EN at edge 3 -> VALID=0, LEVEL=0.
- Push 0..127 on consecutive cycles -> FULL=1 and LEVEL=128 after last push. Extra push of 0xFF -> OVERFLOW=1, LEVEL stays 128. Drain 128 pops -> data 0..127 in order, no 0xFF.
- Fill 100 entries, then push+pop every cycle for 300 cycles -> LEVEL constant 100, output strictly in input order across pointer wrap (write pointer wraps at least twice).
- Pop with empty FIFO -> UNDERFLOW=1, VALID=0, LEVEL=0. UNDERFLOW remains 1 until RSTN=0.
- Threshold check: LEVEL 119->120 -> ALMOST_FULL 0->1. LEVEL 5->4 -> ALMOST_EMPTY 0->1.
- Reset mid-stream with 50 entries and VALID=1 -> next cycle LEVEL=0, VALID=0, flags at reset values. Push 0x3C -> RD_DATA=0x3C, with no stale entry emerging.
